memwb_skid_stage: RTL and testbench
===================================

// Module: memwb_skid_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage for the pipelined CPU, replacing the fixed always-load register.
//  Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and bubble-safe RegWrite gating.
//  Also produces the write-back data mux output.
//  Sits between the data-memory stage (upstream) and the register-file write port (downstream).
// PARAMETERS
//  XLEN             32  width of alu_result / data_rd / wb_data
//  REG_ADDR_W       5   width of rd
//  ZERO_RD_SUPPRESS 1   1: reg_write_o forced 0 when rd_o==0
// PORTS
//  clk_i          in   1           clock, all state on posedge
//  rst_i          in   1           reset, synchronous, active-low
//  flush_i        in   1           synchronous flush of all held beats
//  valid_i        in   1           upstream beat valid
//  ready_o        out  1           stage can accept a beat (registered)
//  reg_write_i    in   1           payload: register write enable
//  mem_to_reg_i   in   1           payload: 1 selects data_rd for write-back
//  alu_result_i   in   XLEN        payload: ALU result
//  data_rd_i      in   XLEN        payload: memory read data
//  rd_i           in   REG_ADDR_W  payload: destination register
//  valid_o        out  1           downstream beat valid
//  ready_i        in   1           downstream accepts beat
//  reg_write_o    out  1           gated write enable (valid_o & reg_write & rd rule)
//  mem_to_reg_o   out  1           held payload
//  alu_result_o   out  XLEN        held payload
//  data_rd_o      out  XLEN        held payload
//  rd_o           out  REG_ADDR_W  held payload
//  wb_data_o      out  XLEN        mem_to_reg_o ? data_rd_o : alu_result_o (combinational)
//  retire_cnt_o   out  32          [MEMWB_STAT_EN only] count of downstream transfers
//  stall_cnt_o    out  32          [MEMWB_STAT_EN only] cycles with valid_o & !ready_i
// BEHAVIOUR
//  - Reset: rst_i==0 at posedge clears out/skid regs and valids.
//    After reset, valid_o=0, ready_o=1, and every payload output, reg_write_o and wb_data_o are 0.
//    Reset overrides flush and all transfers.
//  - in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
//  - ready_o = !skid_valid, taken from a register with no combinational path from ready_i.
//  - Latency: 1 cycle from in_fire to valid_o when the stage is empty.
//    Throughput is 1 beat/cycle while ready_i=1.
//  - States, encoded by out_valid and skid_valid:
//    EMPTY(0,0): in_fire -> BUSY (load out).
//    BUSY(1,0):
//      - in_fire & out_fire -> BUSY (load out).
//      - in_fire & !out_fire -> FULL (load skid).
//      - !in_fire & out_fire -> EMPTY.
//      - otherwise hold.
//    FULL(1,1): ready_o=0, so in_fire cannot occur. out_fire -> BUSY (out <= skid). Otherwise hold.
//  - While valid_o & !ready_i, all payload outputs are stable (no change until out_fire).
//  - Payload regs load only on a load event; otherwise they retain their values (no X capture while invalid).
//  - Flush: flush_i=1 at posedge -> EMPTY next cycle, valid_o=0, ready_o=1.
//    A beat offered in the same cycle is dropped, even if in_fire.
//    Payload regs are not cleared, but reg_write_o=0 because valid_o=0.
//  - reg_write_o = valid_o & reg_write_q & !(ZERO_RD_SUPPRESS & rd_o==0).
//    Bubbles never write the register file.
//  - Beats are never lost or duplicated; order is strictly FIFO.
// CONFIGURATION
//  MEMWB_STAT_EN defined:
//    - retire_cnt_o increments on each out_fire.
//    - stall_cnt_o increments on each cycle with valid_o & !ready_i.
//    - Both are 32-bit, wrap 0xFFFFFFFF -> 0, are cleared by reset, and are not cleared by flush.
//  MEMWB_STAT_EN undefined: both ports and counters are absent; the rest of the behaviour is identical.
// TESTING
//  1. Hold rst_i=0 for 2 cycles with valid_i=1 -> valid_o=0, ready_o=1, reg_write_o=0, all payload/wb_data_o=0.
//  2. ready_i=1; send A(alu=0x10,rd=3,m2r=0,rw=1) then B(data=0xDEADBEEF,rd=5,m2r=1,rw=1) back-to-back
//     -> A valid at cycle+1 with wb_data_o=0x10, then B with wb_data_o=0xDEADBEEF.
//  3. ready_i=0; offer A,B,C -> A held on outputs, B in skid, ready_o=0 from the cycle after B, C held upstream;
//     then ready_i=1 -> A,B,C emitted in order, no gaps after release, no loss or duplication.
//  4. FULL state with valid_i=1 and flush_i=1 -> next cycle valid_o=0, ready_o=1, reg_write_o=0, no beat emitted.
//  5. Beat rd=0, rw=1 -> reg_write_o=0 (ZERO_RD_SUPPRESS=1); rerun with ZERO_RD_SUPPRESS=0 -> reg_write_o=1.
//  6. With MEMWB_STAT_EN: 10 beats with 4 backpressure cycles -> retire_cnt_o=10, stall_cnt_o=4.
//     Without the macro: the module elaborates without the counter ports.

Source files
------------

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush,
// bubble-safe RegWrite gating and write-back mux. Define MEMWB_STAT_EN for retire/stall counters.
module memwb_skid_stage #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned ZERO_RD_SUPPRESS = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  reg_write_i,
  input  logic                  mem_to_reg_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       data_rd_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  reg_write_o,
  output logic                  mem_to_reg_o,
  output logic [XLEN-1:0]       alu_result_o,
  output logic [XLEN-1:0]       data_rd_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       wb_data_o
`ifdef MEMWB_STAT_EN
  ,
  output logic [31:0]           retire_cnt_o,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int unsigned PW = 2 + 2 * XLEN + REG_ADDR_W;

  logic [PW-1:0] in_beat;
  logic [PW-1:0] out_beat_q, out_beat_d;
  logic [PW-1:0] skid_beat_q, skid_beat_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          ready_q, ready_d;
  logic          out_rw;
  logic          in_fire, out_fire;

  assign in_beat = {reg_write_i, mem_to_reg_i, alu_result_i, data_rd_i, rd_i};
  assign {out_rw, mem_to_reg_o, alu_result_o, data_rd_o, rd_o} = out_beat_q;

  assign ready_o  = ready_q;
  assign valid_o  = out_valid_q;
  assign in_fire  = valid_i & ready_q;
  assign out_fire = out_valid_q & ready_i;

  assign wb_data_o   = mem_to_reg_o ? data_rd_o : alu_result_o;
  assign reg_write_o = out_valid_q & out_rw & ~((ZERO_RD_SUPPRESS != 0) && (rd_o == '0));

  // State is implied by (out_valid, skid_valid): EMPTY=00, BUSY=10, FULL=11.
  always_comb begin
    out_beat_d   = out_beat_q;
    skid_beat_d  = skid_beat_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      if (in_fire) begin
        out_beat_d  = in_beat;
        out_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (in_fire && out_fire) begin
        out_beat_d = in_beat;
      end else if (in_fire) begin
        skid_beat_d  = in_beat;
        skid_valid_d = 1'b1;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end else if (out_fire) begin
      out_beat_d   = skid_beat_q;
      skid_valid_d = 1'b0;
    end
    // Registered so ready_o never depends combinationally on ready_i.
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_beat_q   <= '0;
      skid_beat_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      out_beat_q   <= out_beat_d;
      skid_beat_q  <= skid_beat_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

`ifdef MEMWB_STAT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counters survive flush; only reset clears them.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (out_fire) retire_cnt_d = retire_cnt_q + 32'd1;
    if (out_valid_q && !ready_i) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Randomized + directed bench for memwb_skid_stage against a queue-based reference model.
// Counter checks are active when MEMWB_STAT_EN is defined.
module tb_memwb_skid_stage;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic        reg_write_i, mem_to_reg_i;
  logic [31:0] alu_result_i, data_rd_i;
  logic [4:0]  rd_i;
  logic        ready_o, valid_o, reg_write_o, mem_to_reg_o;
  logic [31:0] alu_result_o, data_rd_o, wb_data_o;
  logic [4:0]  rd_o;
  logic        nz_ready_o, nz_valid_o, nz_reg_write_o, nz_mem_to_reg_o;
  logic [31:0] nz_alu_result_o, nz_data_rd_o, nz_wb_data_o;
  logic [4:0]  nz_rd_o;
`ifdef MEMWB_STAT_EN
  logic [31:0] retire_cnt_o, stall_cnt_o, nz_retire_cnt_o, nz_stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  memwb_skid_stage #(.XLEN(32), .REG_ADDR_W(5), .ZERO_RD_SUPPRESS(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i), .alu_result_i(alu_result_i),
    .data_rd_i(data_rd_i), .rd_i(rd_i), .valid_o(valid_o), .ready_i(ready_i),
    .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .alu_result_o(alu_result_o),
    .data_rd_o(data_rd_o), .rd_o(rd_o), .wb_data_o(wb_data_o)
`ifdef MEMWB_STAT_EN
    , .retire_cnt_o(retire_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  memwb_skid_stage #(.XLEN(32), .REG_ADDR_W(5), .ZERO_RD_SUPPRESS(0)) dut_nz (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(nz_ready_o),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i), .alu_result_i(alu_result_i),
    .data_rd_i(data_rd_i), .rd_i(rd_i), .valid_o(nz_valid_o), .ready_i(ready_i),
    .reg_write_o(nz_reg_write_o), .mem_to_reg_o(nz_mem_to_reg_o), .alu_result_o(nz_alu_result_o),
    .data_rd_o(nz_data_rd_o), .rd_o(nz_rd_o), .wb_data_o(nz_wb_data_o)
`ifdef MEMWB_STAT_EN
    , .retire_cnt_o(nz_retire_cnt_o), .stall_cnt_o(nz_stall_cnt_o)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  beat_t       mq[$];
  int unsigned exp_retire = 0;
  int unsigned exp_stall  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.rw   = 1'($urandom_range(0, 3) != 0);
    b.m2r  = 1'($urandom_range(0, 1));
    b.alu  = $urandom;
    b.data = $urandom;
    b.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    return b;
  endfunction

  function automatic beat_t mk(input logic rw, input logic m2r, input logic [31:0] alu,
                               input logic [31:0] data, input logic [4:0] rd);
    beat_t b;
    b.rw = rw; b.m2r = m2r; b.alu = alu; b.data = data; b.rd = rd;
    return b;
  endfunction

  task automatic drive(input logic v, input beat_t b, input logic rdy, input logic fl);
    valid_i      = v;
    reg_write_i  = b.rw;
    mem_to_reg_i = b.m2r;
    alu_result_i = b.alu;
    data_rd_i    = b.data;
    rd_i         = b.rd;
    ready_i      = rdy;
    flush_i      = fl;
  endtask

  // One clock: drive at negedge, check outputs against the model, then advance the model.
  task automatic step(input logic v, input beat_t b, input logic rdy, input logic fl);
    beat_t head;
    logic  ev;
    @(negedge clk_i);
    drive(v, b, rdy, fl);
    #1;
    ev   = (mq.size() != 0);
    head = ev ? mq[0] : '0;
    check_eq("valid_o", 64'(valid_o), 64'(ev));
    check_eq("ready_o", 64'(ready_o), 64'(mq.size() < 2));
    check_eq("reg_write_o", 64'(reg_write_o), 64'(ev && head.rw && head.rd != 5'd0));
    check_eq("nz_reg_write_o", 64'(nz_reg_write_o), 64'(ev && head.rw));
    if (ev) begin
      check_eq("rd_o", 64'(rd_o), 64'(head.rd));
      check_eq("mem_to_reg_o", 64'(mem_to_reg_o), 64'(head.m2r));
      check_eq("alu_result_o", 64'(alu_result_o), 64'(head.alu));
      check_eq("data_rd_o", 64'(data_rd_o), 64'(head.data));
      check_eq("wb_data_o", 64'(wb_data_o), 64'(head.m2r ? head.data : head.alu));
    end
`ifdef MEMWB_STAT_EN
    check_eq("retire_cnt_o", 64'(retire_cnt_o), 64'(exp_retire));
    check_eq("stall_cnt_o", 64'(stall_cnt_o), 64'(exp_stall));
`endif
    if (ev && rdy)  exp_retire++;
    if (ev && !rdy) exp_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      logic acc;
      acc = v && (mq.size() < 2);
      if (ev && rdy) void'(mq.pop_front());
      if (acc) mq.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b1, rand_beat(), 1'b1, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst valid_o", 64'(valid_o), 64'd0);
    check_eq("rst ready_o", 64'(ready_o), 64'd1);
    check_eq("rst reg_write_o", 64'(reg_write_o), 64'd0);
    check_eq("rst payload", {31'd0, mem_to_reg_o, rd_o, alu_result_o[27:0]}, 64'd0);
    check_eq("rst alu_data", {alu_result_o, data_rd_o}, 64'd0);
    check_eq("rst wb_data_o", 64'(wb_data_o), 64'd0);
`ifdef MEMWB_STAT_EN
    check_eq("rst retire_cnt_o", 64'(retire_cnt_o), 64'd0);
    check_eq("rst stall_cnt_o", 64'(stall_cnt_o), 64'd0);
`endif
    rst_i   = 1'b1;
    valid_i = 1'b0;
    mq.delete();
    exp_retire = 0;
    exp_stall  = 0;
  endtask

  initial begin
    beat_t a, b, c, z;
    rst_i = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    do_reset();

    a = mk(1'b1, 1'b0, 32'h10, 32'h0, 5'd3);
    b = mk(1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 5'd5);
    c = mk(1'b1, 1'b0, 32'h77, 32'h1234, 5'd7);
    z = mk(1'b1, 1'b0, 32'h55, 32'h0, 5'd0);

    // Back-to-back with ready_i=1.
    step(1'b1, a, 1'b1, 1'b0);
    step(1'b1, b, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A out, B skid, C held upstream, then release.
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, c, 1'b1, 1'b0);
    step(1'b1, c, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush from FULL with a beat offered.
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // rd=0 write suppression (checked on both instances).
    step(1'b1, z, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // 10 beats with 4 backpressure cycles.
    do_reset();
    step(1'b1, rand_beat(), 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step(1'b1, rand_beat(), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
`ifdef MEMWB_STAT_EN
    check_eq("retire_cnt_10", 64'(retire_cnt_o), 64'd10);
    check_eq("stall_cnt_4", 64'(stall_cnt_o), 64'd4);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_beat(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
